instr_mem_loadable: RTL
=======================

Name: instr_mem_loadable

Overview:
- Parametrised successor to the fixed-program instruction memory: RAM-backed, loaded at run time through a program-load port, with a registered (1-cycle) fetch port.
- Feeds the IF stage of the ARM-subset pipeline; honours pipeline freeze so hazard stalls hold the fetched word.
- Internal init FSM zero-fills the array after reset, then accepts a program, then serves fetches.

Parameters:
- DATA_W, 32, instruction width in bits (multiple of 8).
- ADDR_W, 32, byte-address width of fetch_addr/load_addr.
- DEPTH, 64, number of instruction words (power of two, >=2); word index = addr[OFF+log2(DEPTH)-1:OFF], OFF = log2(DATA_W/8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_we  in  1  program-load write strobe.
- load_addr  in  ADDR_W  byte address of the load word.
- load_data  in  DATA_W  word to write.
- load_done  in  1  one-cycle pulse: program load complete.
- freeze  in  1  pipeline stall; hold fetch outputs.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address (PC).
- instruction  out  DATA_W  fetched word, registered.
- instr_valid  out  1  instruction holds a valid fetch result.
- state_o  out  2  FSM state: 0=CLEAR, 1=LOAD, 2=RUN.
- fault  out  1  address fault (only with INSTR_MEM_BOUNDS_CHECK_EN; otherwise tied 0).

Behaviour:
- Reset (rst=1 at an edge): state=CLEAR, clear counter=0, instruction=0, instr_valid=0, fault=0. Reset asserted in any state aborts that state and restarts CLEAR. Array contents are not reset directly.
- CLEAR: writes 0 to word[counter] each cycle and increments the counter. When the counter reaches DEPTH-1, it writes the last word and moves to LOAD on the next edge. CLEAR lasts exactly DEPTH cycles.
  - load_we, load_done and fetch_req are ignored in CLEAR.
- LOAD: load_we=1 writes load_data to word index of load_addr at the edge.
  - load_done=1 moves to RUN at the next edge. A write in the same cycle as load_done is still performed.
  - fetch_req is ignored: instr_valid=0.
- RUN:
  - Fetch: fetch_req=1 and freeze=0 at edge N gives instruction = word[index(fetch_addr)] and instr_valid=1 after edge N. Latency is 1 cycle, with one fetch accepted per cycle.
  - fetch_req=0 and freeze=0: instr_valid clears to 0; instruction holds its last value.
  - freeze=1: instruction, instr_valid and fault all hold; fetch_req is ignored.
  - load_we remains legal in RUN. A write and a fetch to the same word in the same cycle read the old data (read-first).
  - load_done is ignored in RUN. Only rst leaves RUN.
- Address low OFF bits are ignored for indexing.
- Bits above the index range: address wraps modulo DEPTH words, unless the option below is enabled.
- Unwritten words read as 0.

Optional Feature:
- Macro: INSTR_MEM_BOUNDS_CHECK_EN.
- With the macro:
  - Fetch with a misaligned address (addr[OFF-1:0]!=0) or addr >= DEPTH*(DATA_W/8): instruction=0, instr_valid=1, fault=1, registered like a normal fetch.
  - A good fetch clears fault.
  - Out-of-range or misaligned load writes are dropped and pulse fault for one cycle, unless a fetch result updates fault in the same cycle; the fetch result has priority.
- Without the macro: no checks are made, addresses wrap and low bits are ignored, and fault is constant 0.

Decomposition:
- Shared package instr_mem_pkg: state encoding (ST_CLEAR=2'd0, ST_LOAD=2'd1, ST_RUN=2'd2), NOP word constant (32'h0), and a clog2 helper for OFF and the index width.
- One natural sub-module, instr_mem_array: DEPTH x DATA_W, single write port, registered read-first read port. The parent holds the FSM, clear counter, address decode and fault logic.

Test Plan:
- Reset then idle, DEPTH=64: state_o=0 for exactly 64 cycles, then 1; instr_valid=0 throughout; all words read 0 after RUN.
- Load 0xE3A00014@0x0, 0xE3A01A01@0x4, pulse load_done; fetch 0x4 then 0x0 back-to-back: instruction=0xE3A01A01, then 0xE3A00014 on consecutive cycles, instr_valid=1 both.
- Freeze: fetch 0x0 then assert freeze for 3 cycles while fetch_addr=0x4: output stays 0xE3A00014/valid=1; freeze low gives 0xE3A01A01 next cycle.
- RUN write+fetch same word: write 0xEAFFFFFF@0x8 while fetching 0x8 (old 0): returns 0; next fetch of 0x8 returns 0xEAFFFFFF.
- Bounds (macro on): fetch 0x102 gives fault=1, instruction=0; fetch 0x100 (DEPTH=64) gives fault=1; fetch 0x8 gives fault=0. Macro off: fetch 0x108 returns word at 0x8.
- rst asserted mid-LOAD and mid-RUN: state_o=0 next cycle, outputs 0, previously loaded words read 0 after the new CLEAR.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the loadable instruction memory:
// FSM state codes, the NOP word and a constant-time clog2 helper.
package instr_mem_pkg;

  // FSM state encoding, also visible on state_o
  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // Word returned for cleared memory and faulting fetches
  localparam logic [31:0] NOP_WORD = 32'h0;

  // Ceiling log2, usable in parameter/localparam expressions; clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : instr_mem_pkg

// File: rtl/instr_mem_loadable_if.sv
// Program-load / fetch bus of the loadable instruction memory.
// master: the pipeline / loader side, slave: the memory.
interface instr_mem_loadable_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              freeze;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic [1:0]        state_o;
  logic              fault;

  modport master (
    output load_we,
    output load_addr,
    output load_data,
    output load_done,
    output freeze,
    output fetch_req,
    output fetch_addr,
    input  instruction,
    input  instr_valid,
    input  state_o,
    input  fault
  );

  modport slave (
    input  load_we,
    input  load_addr,
    input  load_data,
    input  load_done,
    input  freeze,
    input  fetch_req,
    input  fetch_addr,
    output instruction,
    output instr_valid,
    output state_o,
    output fault
  );

endinterface : instr_mem_loadable_if

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W storage: one write port and a registered, read-first read
// port. The read register resets to NOP and holds when no read is issued;
// rzero_i replaces the read data with NOP (used for faulting fetches).
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rzero_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: samples pre-write contents, so a same-cycle write is not seen
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= DATA_W'(NOP_WORD);
    end else if (re_i) begin
      rdata_q <= rzero_i ? DATA_W'(NOP_WORD) : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : instr_mem_array

// File: rtl/instr_mem_loadable.sv
// RAM-backed instruction memory for the IF stage. After reset an init FSM
// zero-fills the array (CLEAR), then accepts a program (LOAD) and finally
// serves registered 1-cycle fetches (RUN) that honour pipeline freeze.
// Optional feature macro: INSTR_MEM_BOUNDS_CHECK_EN (misaligned/out-of-range
// fetches return NOP with fault=1; such loads are dropped and pulse fault).
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_loadable_if.slave bus
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF   = clog2(BYTES);
  localparam int unsigned IDX_W = clog2(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;

  logic [IDX_W-1:0]  load_idx_c;
  logic [IDX_W-1:0]  fetch_idx_c;
  logic              fetch_bad_c;
  logic              load_bad_c;
  logic              fetch_upd_c;
  logic              arr_we_c;
  logic [IDX_W-1:0]  arr_waddr_c;
  logic [DATA_W-1:0] arr_wdata_c;
  logic [DATA_W-1:0] rdata_c;

  // Word index: drop byte-offset bits, wrap modulo DEPTH
  assign load_idx_c  = IDX_W'(bus.load_addr >> OFF);
  assign fetch_idx_c = IDX_W'(bus.fetch_addr >> OFF);

`ifdef INSTR_MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);

  logic fault_q;
  logic fetch_fault_q;
  logic load_flt_c;

  // Misaligned or beyond the last word
  assign fetch_bad_c = ((bus.fetch_addr & OFF_MASK) != '0) ||
                       ((bus.fetch_addr >> (OFF + IDX_W)) != '0);
  assign load_bad_c  = ((bus.load_addr & OFF_MASK) != '0) ||
                       ((bus.load_addr >> (OFF + IDX_W)) != '0);
  assign load_flt_c  = bus.load_we && load_bad_c &&
                       ((state_q == ST_LOAD) || (state_q == ST_RUN));

  // Fault: fetch result wins, a dropped load pulses it over the fetch status
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q       <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      if (fetch_upd_c) begin
        fetch_fault_q <= fetch_bad_c;
      end
      if (fetch_upd_c) begin
        fault_q <= fetch_bad_c;
      end else if (load_flt_c) begin
        fault_q <= 1'b1;
      end else begin
        fault_q <= fetch_fault_q;
      end
    end
  end

  assign bus.fault = fault_q;
`else
  assign fetch_bad_c = 1'b0;
  assign load_bad_c  = 1'b0;
  assign bus.fault   = 1'b0;
`endif

  // Next-state, clear sweep, array write selection and fetch acceptance
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    arr_we_c    = 1'b0;
    arr_waddr_c = load_idx_c;
    arr_wdata_c = bus.load_data;
    fetch_upd_c = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        arr_we_c    = 1'b1;
        arr_waddr_c = cnt_q;
        arr_wdata_c = DATA_W'(NOP_WORD);
        cnt_d       = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        arr_we_c = bus.load_we && !load_bad_c;
        if (bus.load_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        arr_we_c    = bus.load_we && !load_bad_c;
        fetch_upd_c = bus.fetch_req && !bus.freeze;
        valid_d     = bus.freeze ? valid_q : bus.fetch_req;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // State, clear counter and valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we_c && !rst),
    .waddr_i (arr_waddr_c),
    .wdata_i (arr_wdata_c),
    .re_i    (fetch_upd_c && !rst),
    .rzero_i (fetch_bad_c),
    .raddr_i (fetch_idx_c),
    .rdata_o (rdata_c)
  );

  assign bus.instruction = rdata_c;
  assign bus.instr_valid = valid_q;
  assign bus.state_o     = state_q;

endmodule : instr_mem_loadable
